uart_tx_framer: RTL and testbench
=================================

Name: uart_tx_framer

Overview:
- Parametrised successor to the UART TX serializer. Contains a full frame engine: start bit, 5..MAX_DATA_WD data bits, optional parity, and 1 or 2 stop bits.
- Has an internal per-bit prescaler, so bits are timed internally rather than by an external ser_en.
- Has a one-entry holding register, so the next byte can be queued while the current frame is on the line.
- Sits between the TX FIFO/system controller and the TX pin.

Parameters:
- MAX_DATA_WD, 8, widest supported data field in bits (≥5).
- CNT_WD, 4, width of the data-length field and bit counter; must satisfy 2^CNT_WD > MAX_DATA_WD.
- PRESCALE_WD, 16, width of the bit-period reload value.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  asynchronous, active-low reset.
- P_DATA  in  MAX_DATA_WD  parallel byte; the LSBs are used when data_len < MAX_DATA_WD.
- Data_Valid  in  1  write strobe into the holding register.
- Data_Ready  out  1  holding register empty; a write is accepted only when this is high.
- data_len  in  CNT_WD  data bits per frame; 0 or > MAX_DATA_WD is treated as MAX_DATA_WD; values 1..4 are treated as 5.
- par_en  in  1  parity bit enable.
- par_typ  in  1  parity type: 0 = even, 1 = odd.
- stop2  in  1  stop bits: 1 = two stop bits, 0 = one.
- msb_first  in  1  data bit order: 1 = MSB of the data field first, 0 = LSB first.
- prescale  in  PRESCALE_WD  bit period in clocks = prescale+1.
- TX_OUT  out  1  serial line, idle high, registered.
- Busy  out  1  high while a frame is on the line (states START..STOP).
- frame_done  out  1  one-cycle pulse at the end of each frame.

Behaviour:
- Reset values (async, RST low): TX_OUT=1, Busy=0, Data_Ready=1, frame_done=0, state=IDLE, hold and shift registers cleared, bit and prescale counters 0.
  - Reset mid-frame aborts the frame immediately; any queued byte is discarded.
- Handshake:
  - Data_Valid && Data_Ready at a rising edge: P_DATA is loaded into hold, and Data_Ready drops after that edge.
  - Data_Valid while Data_Ready=0 is ignored; the held byte is never overwritten.
  - Data_Ready rises on the edge that moves hold into the shift register.
- States: IDLE, START, DATA, PARITY, STOP.
  - IDLE -> START: on the first edge with hold full.
    - On that edge: hold moves to shift; data_len, par_en, par_typ, stop2, msb_first and prescale are latched for the whole frame; the parity of the data_len-bit field is computed; TX_OUT=0.
    - Latency: a Data_Valid sampled at edge N in IDLE gives TX_OUT=0 after edge N+1.
  - Each non-IDLE state holds for prescale+1 clocks, counted by a down-counter reloaded on every bit.
  - START -> DATA: emits the first data bit.
  - DATA: shift by one per bit period. After data_len bits, go to PARITY if par_en, otherwise STOP.
  - PARITY: TX_OUT = XOR of the data bits, XOR par_typ. Then go to STOP.
  - STOP: TX_OUT=1 for one bit period, or two if stop2.
- End of the final stop period:
  - frame_done=1 for exactly that one cycle.
  - If hold is full, go directly to START with no idle bit (back-to-back frames).
  - Otherwise go to IDLE; Busy=0 and TX_OUT stays 1.
- Busy=1 from the START edge through the last STOP cycle; Busy is held 1 across back-to-back frames.
- Config changes mid-frame have no effect until the next frame start.
- prescale=0 gives one clock per bit. The maximum value gives 2^PRESCALE_WD clocks per bit with no overflow; counters wrap only by reload.
- Data bits above the effective data_len are never transmitted and never enter the parity calculation.
- Frame length in clocks = (1 + len + par_en + 1 + stop2) × (prescale+1).

Test Plan:
- Basic frame: prescale=3, data_len=8, par_en=0, stop2=0, LSB-first, byte 0xA5 -> TX_OUT sequence 0,1,0,1,0,0,1,0,1,1 with each bit 4 clocks wide; frame_done pulses 40 clocks after START; Busy is 0 afterwards.
- Parity and two stop bits: byte 0x07, data_len=8, par_en=1, par_typ=0, stop2=1, prescale=0 -> parity bit 1; frame is 12 bits long; par_typ=1 gives parity bit 0.
- Short word, MSB-first: data_len=5, msb_first=1, P_DATA=0xF3 -> transmits bits 4..0 of 0x13 as 1,0,0,1,1; upper bits are ignored, including in the parity calculation.
- Queue and back-to-back: write 0x11, then write 0x22 mid-frame (accepted, Data_Ready drops); a third write while Data_Ready=0 is ignored -> the start bit of the 0x22 frame immediately follows the stop bit of the 0x11 frame; Busy stays high throughout; frame_done pulses twice.
- Config isolation: change prescale from 3 to 7 during the DATA state -> current frame keeps 4-clock bits; the next frame uses 8-clock bits.
- Reset mid-frame: assert RST during the DATA state with hold full -> TX_OUT=1, Busy=0, Data_Ready=1 immediately; no frame follows after release until a new write.

Source files
------------

// File: rtl/uart_tx_framer.sv
// UART transmit framer: start bit, 5..MAX_DATA_WD data bits, optional parity,
// 1 or 2 stop bits, internal bit-period prescaler and a one-entry holding register.
module uart_tx_framer #(
    parameter int MAX_DATA_WD = 8,
    parameter int CNT_WD      = 4,
    parameter int PRESCALE_WD = 16
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [MAX_DATA_WD-1:0] P_DATA,
    input  logic                   Data_Valid,
    output logic                   Data_Ready,
    input  logic [CNT_WD-1:0]      data_len,
    input  logic                   par_en,
    input  logic                   par_typ,
    input  logic                   stop2,
    input  logic                   msb_first,
    input  logic [PRESCALE_WD-1:0] prescale,
    output logic                   TX_OUT,
    output logic                   Busy,
    output logic                   frame_done
);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                 state_q, state_d;
    logic [MAX_DATA_WD-1:0] hold_q, hold_d;
    logic                   full_q, full_d;
    logic [MAX_DATA_WD-1:0] shift_q, shift_d;
    logic [CNT_WD-1:0]      bit_q, bit_d;
    logic [PRESCALE_WD-1:0] pre_cnt_q, pre_cnt_d;
    logic [PRESCALE_WD-1:0] pre_q, pre_d;
    logic                   tx_q, tx_d;
    logic                   done_q, done_d;
    logic                   par_en_q, par_en_d;
    logic                   par_bit_q, par_bit_d;
    logic                   stop2_q, stop2_d;

    logic [CNT_WD-1:0]      eff_len;
    logic [MAX_DATA_WD-1:0] field, field_rev;
    logic                   tick, load;

    // Field is always shifted out LSB first; MSB-first order is produced by
    // reversing the effective field at load time.
    always_comb begin
        eff_len = CNT_WD'(MAX_DATA_WD);
        if (data_len != '0 && data_len <= CNT_WD'(MAX_DATA_WD))
            eff_len = (data_len < CNT_WD'(5)) ? CNT_WD'(5) : data_len;
        field     = '0;
        field_rev = '0;
        for (int unsigned i = 0; i < MAX_DATA_WD; i++) begin
            if (i < 32'(eff_len)) begin
                field[i] = hold_q[i];
                for (int unsigned j = 0; j < MAX_DATA_WD; j++)
                    if (j == 32'(eff_len) - 1 - i) field_rev[i] = hold_q[j];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        full_d    = full_q;
        shift_d   = shift_q;
        bit_d     = bit_q;
        pre_cnt_d = pre_cnt_q;
        pre_d     = pre_q;
        tx_d      = tx_q;
        done_d    = 1'b0;
        par_en_d  = par_en_q;
        par_bit_d = par_bit_q;
        stop2_d   = stop2_q;
        load      = 1'b0;
        tick      = (pre_cnt_q == '0);

        if (Data_Valid && !full_q) begin
            hold_d = P_DATA;
            full_d = 1'b1;
        end

        if (state_q != IDLE)
            pre_cnt_d = tick ? pre_q : pre_cnt_q - 1'b1;

        case (state_q)
            IDLE: load = full_q;
            START: if (tick) begin
                state_d = DATA;
                tx_d    = shift_q[0];
                shift_d = shift_q >> 1;
            end
            DATA: if (tick) begin
                if (bit_q != '0) begin
                    tx_d    = shift_q[0];
                    shift_d = shift_q >> 1;
                    bit_d   = bit_q - 1'b1;
                end else if (par_en_q) begin
                    state_d = PARITY;
                    tx_d    = par_bit_q;
                end else begin
                    state_d = STOP;
                    tx_d    = 1'b1;
                    bit_d   = CNT_WD'(stop2_q);
                end
            end
            PARITY: if (tick) begin
                state_d = STOP;
                tx_d    = 1'b1;
                bit_d   = CNT_WD'(stop2_q);
            end
            STOP: if (tick) begin
                if (bit_q != '0) begin
                    bit_d = bit_q - 1'b1;
                end else begin
                    done_d = 1'b1;
                    if (full_q) load = 1'b1;
                    else        state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Frame start: config is latched here and held for the whole frame.
        if (load) begin
            state_d   = START;
            tx_d      = 1'b0;
            full_d    = 1'b0;
            shift_d   = msb_first ? field_rev : field;
            bit_d     = eff_len - 1'b1;
            pre_cnt_d = prescale;
            pre_d     = prescale;
            par_en_d  = par_en;
            par_bit_d = (^field) ^ par_typ;
            stop2_d   = stop2;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= IDLE;
            hold_q    <= '0;
            full_q    <= 1'b0;
            shift_q   <= '0;
            bit_q     <= '0;
            pre_cnt_q <= '0;
            pre_q     <= '0;
            tx_q      <= 1'b1;
            done_q    <= 1'b0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            stop2_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            full_q    <= full_d;
            shift_q   <= shift_d;
            bit_q     <= bit_d;
            pre_cnt_q <= pre_cnt_d;
            pre_q     <= pre_d;
            tx_q      <= tx_d;
            done_q    <= done_d;
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
            stop2_q   <= stop2_d;
        end
    end

    assign Data_Ready = ~full_q;
    assign Busy       = (state_q != IDLE);
    assign TX_OUT     = tx_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_uart_tx_framer.sv
// Directed testbench for uart_tx_framer with hand-computed line sequences.
module tb_uart_tx_framer;

    localparam int MAX_DATA_WD = 8;
    localparam int CNT_WD      = 4;
    localparam int PRESCALE_WD = 16;

    logic                   CLK = 1'b0;
    logic                   RST;
    logic [MAX_DATA_WD-1:0] P_DATA;
    logic                   Data_Valid;
    logic                   Data_Ready;
    logic [CNT_WD-1:0]      data_len;
    logic                   par_en, par_typ, stop2, msb_first;
    logic [PRESCALE_WD-1:0] prescale;
    logic                   TX_OUT, Busy, frame_done;

    int n_checks = 0;
    int n_errors = 0;

    uart_tx_framer #(
        .MAX_DATA_WD(MAX_DATA_WD),
        .CNT_WD     (CNT_WD),
        .PRESCALE_WD(PRESCALE_WD)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .P_DATA    (P_DATA),
        .Data_Valid(Data_Valid),
        .Data_Ready(Data_Ready),
        .data_len  (data_len),
        .par_en    (par_en),
        .par_typ   (par_typ),
        .stop2     (stop2),
        .msb_first (msb_first),
        .prescale  (prescale),
        .TX_OUT    (TX_OUT),
        .Busy      (Busy),
        .frame_done(frame_done)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic write_byte(input logic [7:0] d);
        Data_Valid = 1'b1;
        P_DATA     = d;
        step();
        Data_Valid = 1'b0;
    endtask

    // Called just after the edge that starts a frame; returns just after the
    // edge that ends it. bits[k] is the k-th bit on the line.
    task automatic check_frame(input string tag, input logic [15:0] bits,
                               input int nbits, input int width);
        logic [15:0] b_v;
        b_v = bits;
        for (int b = 0; b < nbits; b++) begin
            for (int c = 0; c < width; c++) begin
                check($sformatf("%s tx bit%0d c%0d", tag, b, c), {31'b0, TX_OUT}, {31'b0, b_v[0]});
                check($sformatf("%s busy bit%0d c%0d", tag, b, c), {31'b0, Busy}, 32'd1);
                if (b != 0 || c != 0)
                    check($sformatf("%s done early bit%0d", tag, b), {31'b0, frame_done}, 32'd0);
                step();
            end
            b_v = b_v >> 1;
        end
        check($sformatf("%s frame_done", tag), {31'b0, frame_done}, 32'd1);
    endtask

    initial begin
        RST        = 1'b0;
        P_DATA     = '0;
        Data_Valid = 1'b0;
        data_len   = 4'd8;
        par_en     = 1'b0;
        par_typ    = 1'b0;
        stop2      = 1'b0;
        msb_first  = 1'b0;
        prescale   = 16'd3;

        repeat (2) step();
        check("rst tx", {31'b0, TX_OUT}, 32'd1);
        check("rst busy", {31'b0, Busy}, 32'd0);
        check("rst ready", {31'b0, Data_Ready}, 32'd1);
        check("rst done", {31'b0, frame_done}, 32'd0);
        RST = 1'b1;
        step();

        // Basic frame, 0xA5, 4 clocks per bit
        write_byte(8'hA5);
        check("t1 ready low", {31'b0, Data_Ready}, 32'd0);
        check("t1 idle tx", {31'b0, TX_OUT}, 32'd1);
        step();
        check("t1 ready back", {31'b0, Data_Ready}, 32'd1);
        check_frame("t1", {6'b0, 1'b1, 8'hA5, 1'b0}, 10, 4);
        check("t1 busy after", {31'b0, Busy}, 32'd0);
        check("t1 tx after", {31'b0, TX_OUT}, 32'd1);
        step();
        check("t1 done one cycle", {31'b0, frame_done}, 32'd0);

        // Even parity and two stop bits, then odd parity with data_len=0 (=8)
        prescale = 16'd0;
        par_en   = 1'b1;
        stop2    = 1'b1;
        write_byte(8'h07);
        step();
        check_frame("t2 even", {4'b0, 2'b11, 1'b1, 8'h07, 1'b0}, 12, 1);
        check("t2 busy after", {31'b0, Busy}, 32'd0);
        step();
        par_typ  = 1'b1;
        data_len = 4'd0;
        write_byte(8'h07);
        step();
        check_frame("t2 odd", {4'b0, 2'b11, 1'b0, 8'h07, 1'b0}, 12, 1);
        check("t2b busy after", {31'b0, Busy}, 32'd0);
        step();

        // 5-bit MSB-first: 0xF3 -> field 10011, even parity over field only = 1
        prescale  = 16'd1;
        data_len  = 4'd5;
        msb_first = 1'b1;
        par_typ   = 1'b0;
        stop2     = 1'b0;
        write_byte(8'hF3);
        step();
        check_frame("t3", 16'h00F2, 8, 2);
        check("t3 busy after", {31'b0, Busy}, 32'd0);
        step();

        // Queue and back-to-back frames; third write while full is dropped
        data_len  = 4'd8;
        msb_first = 1'b0;
        par_en    = 1'b0;
        write_byte(8'h11);
        step();
        fork
            begin
                check_frame("t4 first", {6'b0, 1'b1, 8'h11, 1'b0}, 10, 2);
                check_frame("t4 second", {6'b0, 1'b1, 8'h22, 1'b0}, 10, 2);
            end
            begin
                repeat (4) step();
                Data_Valid = 1'b1;
                P_DATA     = 8'h22;
                step();
                check("t4 queued ready", {31'b0, Data_Ready}, 32'd0);
                P_DATA = 8'h33;
                step();
                Data_Valid = 1'b0;
                check("t4 ignored ready", {31'b0, Data_Ready}, 32'd0);
            end
        join
        check("t4 busy after", {31'b0, Busy}, 32'd0);
        check("t4 ready after", {31'b0, Data_Ready}, 32'd1);
        for (int i = 0; i < 6; i++) begin
            step();
            check("t4 no third tx", {31'b0, TX_OUT}, 32'd1);
            check("t4 no third busy", {31'b0, Busy}, 32'd0);
        end

        // Prescale change mid-frame only affects the next frame
        prescale = 16'd3;
        write_byte(8'h3C);
        step();
        fork
            begin
                check_frame("t5 old", {6'b0, 1'b1, 8'h3C, 1'b0}, 10, 4);
                check_frame("t5 new", {6'b0, 1'b1, 8'hC3, 1'b0}, 10, 8);
            end
            begin
                repeat (6) step();
                prescale   = 16'd7;
                Data_Valid = 1'b1;
                P_DATA     = 8'hC3;
                step();
                Data_Valid = 1'b0;
            end
        join
        check("t5 busy after", {31'b0, Busy}, 32'd0);
        step();

        // Reset in DATA with a queued byte
        prescale = 16'd3;
        write_byte(8'h00);
        step();
        repeat (6) step();
        check("t6 in data tx", {31'b0, TX_OUT}, 32'd0);
        write_byte(8'h55);
        check("t6 queued", {31'b0, Data_Ready}, 32'd0);
        RST = 1'b0;
        #1;
        check("t6 rst tx", {31'b0, TX_OUT}, 32'd1);
        check("t6 rst busy", {31'b0, Busy}, 32'd0);
        check("t6 rst ready", {31'b0, Data_Ready}, 32'd1);
        check("t6 rst done", {31'b0, frame_done}, 32'd0);
        step();
        RST = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            check("t6 post tx", {31'b0, TX_OUT}, 32'd1);
            check("t6 post busy", {31'b0, Busy}, 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
